rr_mux_n: RTL

Parametrised successor to the datapath 4:1 select mux: a CH-channel, N-bit arbitrating multiplexer with valid/ready handshakes and a registered output stage. Instead of a static 2-bit control, the block selects one of CH requesting sources per cycle, either round-robin or fixed priority. It sits where several multicycle-CPU agents share one downstream port, for example instruction fetch, data access and debug sharing the memory bus.

---
 rtl/rr_mux_n.sv | 119 +++++++++++
 1 files changed

// File: rtl/rr_mux_n.sv
// rr_mux_n: CH-channel, N-bit arbitrating mux (round-robin or fixed
// priority) with valid/ready handshakes and a registered output stage.
// Optional burst lock: define RR_MUX_N_LOCK_EN to add the in_last port.
module rr_mux_n #(
    parameter  int N    = 32,
    parameter  int CH   = 4,
    parameter  int MODE = 0,
    localparam int SW   = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   in_valid,
    input  logic [CH*N-1:0] in_data,
`ifdef RR_MUX_N_LOCK_EN
    input  logic [CH-1:0]   in_last,
`endif
    output logic [CH-1:0]   in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
    output logic [SW-1:0]   out_sel
);

    logic            r_valid;
    logic [N-1:0]    r_data;
    logic [SW-1:0]   r_sel;
    logic [SW-1:0]   r_ptr;

    logic            w_load;
    logic            w_hit;
    logic [SW-1:0]   w_idx;
    logic [SW:0]     w_j;
    logic [CH-1:0]   w_gnt;
    logic            w_xfer;
    logic            w_locked;
    logic            w_release;
    logic [N-1:0]    w_ch [CH];

`ifdef RR_MUX_N_LOCK_EN
    logic            r_lock;
    logic [SW-1:0]   r_lock_ch;

    assign w_locked  = r_lock;
    assign w_release = in_last[w_idx];
`else
    assign w_locked  = 1'b0;
    assign w_release = 1'b1;
`endif

    for (genvar g = 0; g < CH; g++) begin : g_ch
        assign w_ch[g] = in_data[g*N +: N];
    end

    assign w_load = !r_valid || out_ready;

    // Pick the winner: locked channel, else first valid scanning from ptr
    // (ptr stays 0 in fixed-priority mode, giving lowest-index-wins).
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        w_j   = '0;
        w_gnt = '0;
        if (w_locked) begin
`ifdef RR_MUX_N_LOCK_EN
            w_idx = r_lock_ch;
            w_hit = in_valid[r_lock_ch];
`endif
        end else begin
            for (int k = 0; k < CH; k++) begin
                w_j = {1'b0, r_ptr} + (SW+1)'(k);
                if (w_j >= (SW+1)'(CH)) begin
                    w_j = w_j - (SW+1)'(CH);
                end
                if (!w_hit && in_valid[w_j[SW-1:0]]) begin
                    w_hit = 1'b1;
                    w_idx = w_j[SW-1:0];
                end
            end
        end
        if (w_hit) begin
            w_gnt[w_idx] = 1'b1;
        end
    end

    assign w_xfer   = w_load && w_hit && !rst;
    assign in_ready = w_xfer ? w_gnt : '0;

    // Output register, pointer and lock state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
`ifdef RR_MUX_N_LOCK_EN
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
`endif
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_ch[w_idx];
            r_sel   <= w_idx;
            if (MODE == 0 && w_release) begin
                r_ptr <= (w_idx == SW'(CH-1)) ? '0 : w_idx + 1'b1;
            end
`ifdef RR_MUX_N_LOCK_EN
            r_lock    <= !w_release;
            r_lock_ch <= w_idx;
`endif
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule
